// File: rtl/uart_parity_engine.sv
// uart_parity_engine: bit-serial even/odd/mark/space parity generator and checker for the UART paths
module uart_parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN = 5,
  localparam int LEN_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic [LEN_W-1:0]      i_data_len,
  input  logic                  i_par_en,
  input  logic [1:0]            i_par_mode,
  input  logic                  i_chk_en,
  input  logic                  i_rx_par,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_par_vld,
  output logic                  o_par_bit,
  output logic                  o_par_err
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(DATA_WIDTH);
  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic [1:0]            r_mode;
  logic                  r_chk;
  logic                  r_rx;
  logic                  r_acc;
  logic                  r_busy;
  logic                  r_vld;
  logic                  r_bit;
  logic                  r_err;
  logic [LEN_W-1:0]      w_len;
  logic [DATA_WIDTH-1:0] w_sh;
  logic                  w_last;
  logic                  w_fold;
  logic                  w_bit;
  logic                  w_start;

  assign w_len   = (i_data_len < MIN_L) ? MIN_L : (i_data_len > MAX_L) ? MAX_L : i_data_len;
  assign w_sh    = r_data >> r_cnt;
  assign w_fold  = r_acc ^ w_sh[0];
  assign w_last  = (r_cnt == r_len - 1'b1);
  assign w_bit   = r_mode[1] ? ~r_mode[0] : (r_mode[0] ? ~w_fold : w_fold);
  assign w_start = (r_state == S_IDLE) && i_load;

  // next state: bypass goes straight to DONE, otherwise CALC walks the L data bits
  always_comb begin
    w_next = (r_state == S_IDLE) ? (i_load ? (i_par_en ? S_CALC : S_DONE) : S_IDLE) :
             (r_state == S_CALC) ? (w_last ? S_DONE : S_CALC) : S_IDLE;
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // operand capture, serial fold and registered results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_mode <= '0;
      r_chk  <= 1'b0;
      r_rx   <= 1'b0;
      r_acc  <= 1'b0;
      r_busy <= 1'b0;
      r_vld  <= 1'b0;
      r_bit  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_start) begin
        r_data <= i_p_data;
        r_len  <= w_len;
        r_mode <= i_par_mode;
        r_chk  <= i_chk_en;
        r_rx   <= i_rx_par;
        r_acc  <= 1'b0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
        if (!i_par_en) begin
          r_vld <= 1'b1;
          r_bit <= 1'b0;
          r_err <= 1'b0;
        end
      end else if (r_state == S_CALC) begin
        r_acc <= w_fold;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_vld <= 1'b1;
          r_bit <= w_bit;
          r_err <= r_chk & (w_bit != r_rx);
        end
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_par_vld = r_vld;
  assign o_par_bit = r_bit;
  assign o_par_err = r_err;
endmodule

// File: tb/tb_uart_parity_engine.sv
// tb_uart_parity_engine: directed and randomized checks of the parity engine against a counting model
module tb_uart_parity_engine;
  localparam int DW = 8;
  localparam int MINL = 5;
  localparam int LW = $clog2(DW + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] p_data = '0;
  logic [LW-1:0] data_len = '0;
  logic par_en = 1'b0;
  logic [1:0] par_mode = 2'b00;
  logic chk_en = 1'b0;
  logic rx_par = 1'b0;
  logic load = 1'b0;
  logic busy, par_vld, par_bit, par_err;
  int n_cmp = 0;
  int n_fail = 0;
  int vld_at, vld_cnt, busy_fall;
  logic pb, pe, pb_end, pe_end;

  always #5 clk = ~clk;

  uart_parity_engine #(.DATA_WIDTH(DW), .MIN_LEN(MINL)) dut (
    .i_clk(clk), .i_rst(rst), .i_p_data(p_data), .i_data_len(data_len),
    .i_par_en(par_en), .i_par_mode(par_mode), .i_chk_en(chk_en), .i_rx_par(rx_par),
    .i_load(load), .o_busy(busy), .o_par_vld(par_vld), .o_par_bit(par_bit), .o_par_err(par_err)
  );

  function automatic int clamp(int len);
    return (len < MINL) ? MINL : ((len > DW) ? DW : len);
  endfunction

  function automatic logic model_bit(logic [DW-1:0] d, int len, logic en, logic [1:0] mode);
    int ones = 0;
    int l = clamp(len);
    for (int i = 0; i < l; i++) ones += int'(d[i]);
    if (!en) return 1'b0;
    case (mode)
      2'd0: return (ones % 2) == 1;
      2'd1: return (ones % 2) == 0;
      2'd2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // one LOAD at edge T, then watch edges T+1..T+12 while scrambling the inputs
  task automatic run_op(input logic [DW-1:0] d, input int len, input logic en, input logic [1:0] mode,
                        input logic chk, input logic rx, input bit hold);
    @(negedge clk);
    p_data = d; data_len = LW'(len); par_en = en; par_mode = mode; chk_en = chk; rx_par = rx; load = 1'b1;
    @(posedge clk); #1;
    if (!hold) load = 1'b0;
    vld_at = -1; vld_cnt = 0; busy_fall = -1;
    if (par_vld) begin vld_at = 0; vld_cnt++; pb = par_bit; pe = par_err; end
    if (!busy) busy_fall = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 6) load = 1'b0;
      p_data = DW'($urandom); data_len = LW'($urandom); par_en = 1'($urandom);
      par_mode = 2'($urandom); chk_en = 1'($urandom); rx_par = 1'($urandom);
      if (par_vld) begin if (vld_at < 0) vld_at = k; vld_cnt++; pb = par_bit; pe = par_err; end
      if (!busy && busy_fall < 0) busy_fall = k;
    end
    pb_end = par_bit; pe_end = par_err;
    load = 1'b0;
  endtask

  task automatic test_reset;
    load = 1'b1;
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, par_vld, par_bit, par_err} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_outputs edge %0d: got %b exp 0000", e, {busy, par_vld, par_bit, par_err});
      end
    end
    @(negedge clk); rst = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, par_vld} !== 2'b00) begin n_fail++; $display("FAIL reset_no_start: got %b exp 00", {busy, par_vld}); end
  endtask

  task automatic test_even_odd;
    logic [1:0] modes [2] = '{2'd0, 2'd1};
    logic exp_b [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      run_op(8'hA7, 8, 1'b1, modes[i], 1'b0, 1'b0, 1'b0);
      n_cmp++; if (pb !== exp_b[i]) begin n_fail++; $display("FAIL even_odd_bit mode %0d: got %b exp %b", modes[i], pb, exp_b[i]); end
      n_cmp++; if (vld_at !== 8 || vld_cnt !== 1) begin n_fail++; $display("FAIL even_odd_vld: at %0d cnt %0d exp at 8 cnt 1", vld_at, vld_cnt); end
      n_cmp++; if (busy_fall !== 9) begin n_fail++; $display("FAIL even_odd_busy_fall: got %0d exp 9", busy_fall); end
    end
  endtask

  task automatic test_clamp;
    int lens [3] = '{5, 2, 12};
    logic exp_b [3] = '{1'b0, 1'b0, 1'b1};
    int exp_v [3] = '{5, 5, 8};
    for (int i = 0; i < 3; i++) begin
      run_op(8'hE3, lens[i], 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (pb !== exp_b[i]) begin n_fail++; $display("FAIL clamp_bit len %0d: got %b exp %b", lens[i], pb, exp_b[i]); end
      n_cmp++; if (vld_at !== exp_v[i] || busy_fall !== exp_v[i] + 1) begin
        n_fail++; $display("FAIL clamp_timing len %0d: vld %0d busy_fall %0d exp %0d/%0d", lens[i], vld_at, busy_fall, exp_v[i], exp_v[i] + 1);
      end
    end
  endtask

  task automatic test_modes;
    logic ens [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] modes [3] = '{2'd2, 2'd3, 2'd2};
    logic exp_b [3] = '{1'b1, 1'b0, 1'b0};
    int exp_v [3] = '{8, 8, 0};
    for (int i = 0; i < 3; i++) begin
      run_op(8'h00, 8, ens[i], modes[i], 1'b0, 1'b0, 1'b0);
      n_cmp++; if (pb !== exp_b[i]) begin n_fail++; $display("FAIL modes_bit case %0d: got %b exp %b", i, pb, exp_b[i]); end
      n_cmp++; if (vld_at !== exp_v[i] || vld_cnt !== 1) begin n_fail++; $display("FAIL modes_vld case %0d: at %0d cnt %0d exp %0d", i, vld_at, vld_cnt, exp_v[i]); end
    end
  endtask

  task automatic test_check;
    logic chks [3] = '{1'b1, 1'b1, 1'b0};
    logic rxs [3] = '{1'b0, 1'b1, 1'b0};
    logic exp_e [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(8'h01, 8, 1'b1, 2'd0, chks[i], rxs[i], 1'b0);
      n_cmp++; if (pe !== exp_e[i]) begin n_fail++; $display("FAIL check_err case %0d: got %b exp %b", i, pe, exp_e[i]); end
      n_cmp++; if (pe_end !== exp_e[i] || pb_end !== 1'b1) begin n_fail++; $display("FAIL check_hold case %0d: err %b bit %b exp %b 1", i, pe_end, pb_end, exp_e[i]); end
    end
  endtask

  task automatic test_busy_hold;
    run_op(8'hA7, 8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (vld_cnt !== 1 || vld_at !== 8) begin n_fail++; $display("FAIL busy_hold_vld: cnt %0d at %0d exp 1 at 8", vld_cnt, vld_at); end
    n_cmp++; if (pb !== 1'b1 || busy_fall !== 9) begin n_fail++; $display("FAIL busy_hold_result: bit %b busy_fall %0d exp 1 9", pb, busy_fall); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_hold_idle: got %b exp 0", busy); end
  endtask

  task automatic test_abort;
    int seen = 0;
    @(negedge clk);
    p_data = 8'hFF; data_len = LW'(8); par_en = 1'b1; par_mode = 2'd1; chk_en = 1'b1; rx_par = 1'b0; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy, par_vld, par_bit, par_err} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_outputs: got %b exp 0000", {busy, par_vld, par_bit, par_err});
    end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (par_vld || busy) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles exp 0", seen); end
    run_op(8'h01, 8, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pb !== 1'b1 || vld_at !== 8) begin n_fail++; $display("FAIL abort_reload: bit %b at %0d exp 1 at 8", pb, vld_at); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      int len = $urandom_range(0, 15);
      logic en = 1'($urandom);
      logic [1:0] mode = 2'($urandom);
      logic chk = 1'($urandom);
      logic rx = 1'($urandom);
      logic eb = model_bit(d, len, en, mode);
      logic ee = en & chk & (eb != rx);
      int ev = en ? clamp(len) : 0;
      run_op(d, len, en, mode, chk, rx, 1'b0);
      n_cmp++; if (pb !== eb || pe !== ee) begin
        n_fail++; $display("FAIL random_result %0d d=%h len=%0d en=%b mode=%0d: bit %b err %b exp %b %b", i, d, len, en, mode, pb, pe, eb, ee);
      end
      n_cmp++; if (vld_at !== ev || vld_cnt !== 1 || busy_fall !== ev + 1) begin
        n_fail++; $display("FAIL random_timing %0d: vld %0d cnt %0d busy_fall %0d exp %0d 1 %0d", i, vld_at, vld_cnt, busy_fall, ev, ev + 1);
      end
      n_cmp++; if (pb_end !== eb || pe_end !== ee) begin
        n_fail++; $display("FAIL random_hold %0d: bit %b err %b exp %b %b", i, pb_end, pe_end, eb, ee);
      end
    end
  endtask

  initial begin
    test_reset;
    test_even_odd;
    test_clamp;
    test_modes;
    test_check;
    test_busy_hold;
    test_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
